mul_issue_ctrl: RTL and testbench
=================================

Name: mul_issue_ctrl

Overview:
- Front-end controller for the shared pipelined integer multiplier (`mul`).
- Arbitrates two issue ports (reqN, N=0,1) round-robin onto the single multiplier. Issues are credit-limited so every in-flight result is guaranteed a slot in a result queue.
- Buffers results for a shared writeback port that can stall (valid/ready).
- Supports pipeline flush: the multiplier has no kill input, so flushed results are dropped here.

Parameters:
- Q_DEPTH, 4, result queue entries; power of 2, >=2.
- LAT, `MUL_LAT+1 (localparam, not overridable), cycles from mul_go to mul_complete.

Ports:
- clk input 1 clock
- reset input 1 synchronous active-high reset
- flush input 1 discard all queued and in-flight ops
- reqN_valid input 1 requester N has an op (N=0,1)
- reqN_ready output 1 op accepted this cycle
- reqN_is_signed / reqN_is_high / reqN_is_64b input 1 each, op controls
- reqN_src_A, reqN_src_B input `M_WIDTH operands
- reqN_rob_ptr input `LG_ROB_ENTRIES
- reqN_prf_ptr input `LG_PRF_ENTRIES
- mul_go output 1; mul_is_signed, mul_is_high, mul_is_64b output 1 each
- mul_src_A, mul_src_B output `M_WIDTH
- mul_rob_ptr output `LG_ROB_ENTRIES; mul_prf_ptr output `LG_PRF_ENTRIES
- mul_y input `M_WIDTH; mul_complete input 1
- mul_rob_ptr_out input `LG_ROB_ENTRIES; mul_prf_ptr_out input `LG_PRF_ENTRIES
- wb_valid output 1; wb_ready input 1
- wb_y output `M_WIDTH; wb_rob_ptr output `LG_ROB_ENTRIES; wb_prf_ptr output `LG_PRF_ENTRIES
- err output 1 sticky: expected completion missing

Behaviour:
- Reset (synchronous): the following are 0 during and after the reset cycle:
  - wb_valid, reqN_ready, mul_go, err
  - queue count and pointers, inflight counter, shadow pipe
  - rr pointer (req0 has priority).
- Credit: can_issue = (q_count + inflight) < Q_DEPTH, computed from registered state only. A same-cycle pop does not free a credit.
- Arbitration:
  - At most one grant per cycle; grant only if can_issue && !flush && !reset.
  - If both requesters are valid, the one selected by the rr pointer wins. After any grant, the rr pointer points to the non-granted requester.
  - reqN_ready = grantN. Requesters hold valid and payload stable until ready.
- Issue:
  - mul_go = grant0 | grant1, in the same cycle as the handshake.
  - mul_* payload is muxed combinationally from the granted requester, and is don't-care when mul_go=0.
- Shadow pipe: LAT-deep valid shift register. Bit 0 is loaded with mul_go at each edge; bit LAT-1 aligns with mul_complete.
- inflight counter: +1 on issue, -1 when the shadow tail is 1; both in one cycle leaves it unchanged.
- Result capture:
  - When mul_complete && shadow[LAT-1], push {mul_y, mul_rob_ptr_out, mul_prf_ptr_out} into the queue.
  - The queue is never full at push (credit invariant). Guard it with an assertion, and no overwrite is allowed.
  - mul_complete while shadow[LAT-1]=0 is a flushed op and is silently dropped.
- Writeback:
  - wb_valid = queue non-empty; wb_* come from the queue head (registered storage).
  - Pop on wb_valid && wb_ready. A simultaneous push and pop keeps q_count unchanged; wrap-around is by pointer modulo Q_DEPTH.
- Latency: accept in cycle t gives mul_complete in t+LAT, and wb_valid in t+LAT+1 if the queue ahead is empty.
- Flush (single cycle):
  - No grant that cycle.
  - At the edge: queue emptied, shadow cleared, inflight=0, wb_valid=0 next cycle.
  - A pop or push coinciding with flush is ignored. The rr pointer is unchanged.
  - Old results arriving later are dropped via the shadow.
- err: set when shadow[LAT-1]=1 && mul_complete=0, sticky until reset.
- Reset mid-operation: all state clears; in-flight multiplier results arrive with shadow=0 and are dropped.

Decomposition:
- Shared package: mul_req_t struct {is_signed, is_high, is_64b, src_A, src_B, rob_ptr, prf_ptr} and mul_res_t {y, rob_ptr, prf_ptr}.
- `MUL_RESULT_Q_DEPTH default goes in machine.vh.
- One sub-module: mul_result_fifo (parameterised depth and width, push/pop/count/flush). The arbiter, credit logic and shadow pipe stay in the top.

Test Plan:
- Single op, MUL_LAT=3 (LAT=4): req0 7*6, unsigned, low, rob=5, prf=9, accepted at cycle 0 -> wb_valid at cycle 5 with y=42, rob=5, prf=9; err=0.
- Contention: both valid every cycle for 6 cycles, wb_ready=1 -> grants alternate 0,1,0,1,0,1. A burst of 4 issues with wb_ready=1 sustains 1 op/cycle.
- Backpressure, Q_DEPTH=4: wb_ready=0, req0 always valid -> exactly 4 accepts then ready=0. Raise wb_ready -> results pop in issue order, then issue resumes. Queue never overflows and no result is lost.
- Flush with 3 ops in flight and 1 queued -> wb_valid=0 next cycle; the 3 late mul_completes are dropped. A new op after flush (src 0xFFFFFFFFFFFFFFFF x same, unsigned 64b high) returns y=0xFFFFFFFFFFFFFFFE.
- Simultaneous push+pop at full-minus-one with pointer wrap -> q_count stable, order preserved across the wrap.
- Fault injection: suppress mul_complete for one issued op -> err=1 at the expected cycle and it stays 1 until reset. Reset asserted mid-burst -> all outputs 0 next cycle and no stale wb_valid afterwards.

Source files
------------

// File: rtl/mul_issue_ctrl_pkg.sv
// Shared types and machine constants for the multiplier issue controller.
// Operand width, pointer widths, multiplier latency and result queue depth live here.
package mul_issue_ctrl_pkg;

    localparam int M_WIDTH            = 64;
    localparam int LG_ROB_ENTRIES     = 6;
    localparam int LG_PRF_ENTRIES     = 7;
    localparam int MUL_LAT            = 3;
    localparam int MUL_RESULT_Q_DEPTH = 4;

    typedef struct packed {
        logic                      is_signed;
        logic                      is_high;
        logic                      is_64b;
        logic [M_WIDTH-1:0]        src_A;
        logic [M_WIDTH-1:0]        src_B;
        logic [LG_ROB_ENTRIES-1:0] rob_ptr;
        logic [LG_PRF_ENTRIES-1:0] prf_ptr;
    } mul_req_t;

    typedef struct packed {
        logic [M_WIDTH-1:0]        y;
        logic [LG_ROB_ENTRIES-1:0] rob_ptr;
        logic [LG_PRF_ENTRIES-1:0] prf_ptr;
    } mul_res_t;

    // A new op may issue only if every result already owed still has a queue slot.
    function automatic logic credit_avail(input int unsigned q_count,
                                          input int unsigned inflight,
                                          input int unsigned depth);
        return (q_count + inflight) < depth;
    endfunction

endpackage

// File: rtl/mul_result_fifo.sv
// Circular result queue with flush; head entry read straight from registered storage.
module mul_result_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 8
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   flush,
    input  logic                   push,
    input  logic [WIDTH-1:0]       push_data,
    input  logic                   pop,
    output logic [WIDTH-1:0]       pop_data,
    output logic [$clog2(DEPTH):0] count,
    output logic                   empty
);

    localparam int PW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_r [DEPTH];
    logic [PW-1:0]    rd_ptr_r;
    logic [PW-1:0]    wr_ptr_r;
    logic [PW:0]      count_r;
    logic             full_s;
    logic             empty_s;
    logic             push_en_s;
    logic             pop_en_s;

    assign empty_s   = (count_r == (PW+1)'(0));
    assign full_s    = (count_r == (PW+1)'(DEPTH));
    assign push_en_s = push && !full_s && !flush;
    assign pop_en_s  = pop && !empty_s && !flush;

    assign pop_data = mem_r[rd_ptr_r];
    assign count    = count_r;
    assign empty    = empty_s;

    // Pointer and occupancy tracking; pointers wrap naturally since DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (reset || flush) begin
            rd_ptr_r <= {PW{1'b0}};
            wr_ptr_r <= {PW{1'b0}};
            count_r  <= {(PW+1){1'b0}};
        end else begin
            if (push_en_s) begin
                wr_ptr_r <= wr_ptr_r + PW'(1);
            end
            if (pop_en_s) begin
                rd_ptr_r <= rd_ptr_r + PW'(1);
            end
            case ({push_en_s, pop_en_s})
                2'b10:   count_r <= count_r + (PW+1)'(1);
                2'b01:   count_r <= count_r - (PW+1)'(1);
                default: count_r <= count_r;
            endcase
        end
    end

    // Entry storage; only written into a free slot.
    always_ff @(posedge clk) begin
        if (push_en_s) begin
            mem_r[wr_ptr_r] <= push_data;
        end
    end

    mul_result_fifo_chk u_chk (
        .clk   (clk),
        .reset (reset),
        .flush (flush),
        .push  (push),
        .full  (full_s)
    );

endmodule

// File: rtl/mul_result_fifo_chk.sv
// Checker for the result queue: a push may never find the queue full.
module mul_result_fifo_chk (
    input logic clk,
    input logic reset,
    input logic flush,
    input logic push,
    input logic full
);

    // Credit accounting guarantees space for every push that is not flushed.
    a_no_overflow: assert property (@(posedge clk) disable iff (reset) !(push && full && !flush));

endmodule

// File: rtl/mul_issue_ctrl.sv
// Round-robin, credit-limited issue of two requesters onto the shared multiplier,
// with a shadow valid pipe that drops flushed results and a buffered writeback port.
module mul_issue_ctrl
    import mul_issue_ctrl_pkg::*;
#(
    parameter int Q_DEPTH = MUL_RESULT_Q_DEPTH
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      flush,
    input  logic                      req0_valid,
    output logic                      req0_ready,
    input  logic                      req0_is_signed,
    input  logic                      req0_is_high,
    input  logic                      req0_is_64b,
    input  logic [M_WIDTH-1:0]        req0_src_A,
    input  logic [M_WIDTH-1:0]        req0_src_B,
    input  logic [LG_ROB_ENTRIES-1:0] req0_rob_ptr,
    input  logic [LG_PRF_ENTRIES-1:0] req0_prf_ptr,
    input  logic                      req1_valid,
    output logic                      req1_ready,
    input  logic                      req1_is_signed,
    input  logic                      req1_is_high,
    input  logic                      req1_is_64b,
    input  logic [M_WIDTH-1:0]        req1_src_A,
    input  logic [M_WIDTH-1:0]        req1_src_B,
    input  logic [LG_ROB_ENTRIES-1:0] req1_rob_ptr,
    input  logic [LG_PRF_ENTRIES-1:0] req1_prf_ptr,
    output logic                      mul_go,
    output logic                      mul_is_signed,
    output logic                      mul_is_high,
    output logic                      mul_is_64b,
    output logic [M_WIDTH-1:0]        mul_src_A,
    output logic [M_WIDTH-1:0]        mul_src_B,
    output logic [LG_ROB_ENTRIES-1:0] mul_rob_ptr,
    output logic [LG_PRF_ENTRIES-1:0] mul_prf_ptr,
    input  logic [M_WIDTH-1:0]        mul_y,
    input  logic                      mul_complete,
    input  logic [LG_ROB_ENTRIES-1:0] mul_rob_ptr_out,
    input  logic [LG_PRF_ENTRIES-1:0] mul_prf_ptr_out,
    output logic                      wb_valid,
    input  logic                      wb_ready,
    output logic [M_WIDTH-1:0]        wb_y,
    output logic [LG_ROB_ENTRIES-1:0] wb_rob_ptr,
    output logic [LG_PRF_ENTRIES-1:0] wb_prf_ptr,
    output logic                      err
);

    localparam int LAT = MUL_LAT + 1;
    localparam int CW  = $clog2(Q_DEPTH) + 1;

    logic           rr_r;
    logic [LAT-1:0] shadow_r;
    logic [CW-1:0]  inflight_r;
    logic           err_r;

    logic           grant0_s;
    logic           grant1_s;
    logic           go_s;
    logic           can_issue_s;
    logic [CW-1:0]  q_count_s;
    logic           q_empty_s;
    logic           push_s;
    logic           wb_valid_s;
    mul_req_t       req0_s;
    mul_req_t       req1_s;
    mul_req_t       sel_s;
    mul_res_t       cap_s;
    mul_res_t       head_s;

    assign can_issue_s = credit_avail(32'(q_count_s), 32'(inflight_r), Q_DEPTH);

    // One grant per cycle; rr_r names the requester that wins a tie.
    always_comb begin
        grant0_s = 1'b0;
        grant1_s = 1'b0;
        if (can_issue_s && !flush && !reset) begin
            if (req0_valid && req1_valid) begin
                grant0_s = !rr_r;
                grant1_s = rr_r;
            end else begin
                grant0_s = req0_valid;
                grant1_s = req1_valid;
            end
        end else begin
            grant0_s = 1'b0;
            grant1_s = 1'b0;
        end
    end

    assign go_s       = grant0_s | grant1_s;
    assign req0_ready = grant0_s;
    assign req1_ready = grant1_s;

    assign req0_s = '{req0_is_signed, req0_is_high, req0_is_64b, req0_src_A, req0_src_B,
                      req0_rob_ptr, req0_prf_ptr};
    assign req1_s = '{req1_is_signed, req1_is_high, req1_is_64b, req1_src_A, req1_src_B,
                      req1_rob_ptr, req1_prf_ptr};
    assign sel_s  = grant1_s ? req1_s : req0_s;

    assign mul_go        = go_s;
    assign mul_is_signed = sel_s.is_signed;
    assign mul_is_high   = sel_s.is_high;
    assign mul_is_64b    = sel_s.is_64b;
    assign mul_src_A     = sel_s.src_A;
    assign mul_src_B     = sel_s.src_B;
    assign mul_rob_ptr   = sel_s.rob_ptr;
    assign mul_prf_ptr   = sel_s.prf_ptr;

    // Arbitration pointer, shadow valid pipe, in-flight credits and sticky error.
    always_ff @(posedge clk) begin
        if (reset) begin
            rr_r       <= 1'b0;
            shadow_r   <= {LAT{1'b0}};
            inflight_r <= {CW{1'b0}};
            err_r      <= 1'b0;
        end else begin
            if (go_s) begin
                rr_r <= grant0_s;
            end
            if (shadow_r[LAT-1] && !mul_complete) begin
                err_r <= 1'b1;
            end
            if (flush) begin
                shadow_r   <= {LAT{1'b0}};
                inflight_r <= {CW{1'b0}};
            end else begin
                shadow_r <= {shadow_r[LAT-2:0], go_s};
                case ({go_s, shadow_r[LAT-1]})
                    2'b10:   inflight_r <= inflight_r + CW'(1);
                    2'b01:   inflight_r <= inflight_r - CW'(1);
                    default: inflight_r <= inflight_r;
                endcase
            end
        end
    end

    // A completion without a live shadow bit belongs to a flushed or reset op.
    assign push_s = mul_complete && shadow_r[LAT-1];
    assign cap_s  = '{mul_y, mul_rob_ptr_out, mul_prf_ptr_out};

    assign wb_valid_s = !q_empty_s && !reset;

    mul_result_fifo #(
        .DEPTH (Q_DEPTH),
        .WIDTH ($bits(mul_res_t))
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .flush     (flush),
        .push      (push_s),
        .push_data (cap_s),
        .pop       (wb_valid_s && wb_ready),
        .pop_data  (head_s),
        .count     (q_count_s),
        .empty     (q_empty_s)
    );

    assign wb_valid   = wb_valid_s;
    assign wb_y       = head_s.y;
    assign wb_rob_ptr = head_s.rob_ptr;
    assign wb_prf_ptr = head_s.prf_ptr;
    assign err        = err_r && !reset;

endmodule

// File: tb/tb_mul_issue_ctrl.sv
// Directed bench for mul_issue_ctrl with a pipelined multiplier stub and an in-order
// scoreboard of expected writeback results.
module tb_mul_issue_ctrl;
    import mul_issue_ctrl_pkg::*;

    localparam int LAT = MUL_LAT + 1;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic reset, flush;
    logic req0_valid, req0_ready, req0_is_signed, req0_is_high, req0_is_64b;
    logic [M_WIDTH-1:0] req0_src_A, req0_src_B;
    logic [LG_ROB_ENTRIES-1:0] req0_rob_ptr;
    logic [LG_PRF_ENTRIES-1:0] req0_prf_ptr;
    logic req1_valid, req1_ready, req1_is_signed, req1_is_high, req1_is_64b;
    logic [M_WIDTH-1:0] req1_src_A, req1_src_B;
    logic [LG_ROB_ENTRIES-1:0] req1_rob_ptr;
    logic [LG_PRF_ENTRIES-1:0] req1_prf_ptr;
    logic mul_go, mul_is_signed, mul_is_high, mul_is_64b;
    logic [M_WIDTH-1:0] mul_src_A, mul_src_B, mul_y;
    logic [LG_ROB_ENTRIES-1:0] mul_rob_ptr, mul_rob_ptr_out;
    logic [LG_PRF_ENTRIES-1:0] mul_prf_ptr, mul_prf_ptr_out;
    logic mul_complete;
    logic wb_valid, wb_ready, err;
    logic [M_WIDTH-1:0] wb_y;
    logic [LG_ROB_ENTRIES-1:0] wb_rob_ptr;
    logic [LG_PRF_ENTRIES-1:0] wb_prf_ptr;

    mul_issue_ctrl dut (
        .clk(clk), .reset(reset), .flush(flush),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_is_signed(req0_is_signed),
        .req0_is_high(req0_is_high), .req0_is_64b(req0_is_64b), .req0_src_A(req0_src_A),
        .req0_src_B(req0_src_B), .req0_rob_ptr(req0_rob_ptr), .req0_prf_ptr(req0_prf_ptr),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_is_signed(req1_is_signed),
        .req1_is_high(req1_is_high), .req1_is_64b(req1_is_64b), .req1_src_A(req1_src_A),
        .req1_src_B(req1_src_B), .req1_rob_ptr(req1_rob_ptr), .req1_prf_ptr(req1_prf_ptr),
        .mul_go(mul_go), .mul_is_signed(mul_is_signed), .mul_is_high(mul_is_high),
        .mul_is_64b(mul_is_64b), .mul_src_A(mul_src_A), .mul_src_B(mul_src_B),
        .mul_rob_ptr(mul_rob_ptr), .mul_prf_ptr(mul_prf_ptr),
        .mul_y(mul_y), .mul_complete(mul_complete),
        .mul_rob_ptr_out(mul_rob_ptr_out), .mul_prf_ptr_out(mul_prf_ptr_out),
        .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_y(wb_y),
        .wb_rob_ptr(wb_rob_ptr), .wb_prf_ptr(wb_prf_ptr), .err(err)
    );

    int n_vec = 0;
    int n_bad = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [63:0] mref(input logic [63:0] a, input logic [63:0] b,
                                         input logic sgn, input logic hi, input logic w64);
        logic [63:0]  a2, b2;
        logic [127:0] p;
        if (w64) begin
            a2 = a;
            b2 = b;
        end else begin
            a2 = sgn ? {{32{a[31]}}, a[31:0]} : {32'd0, a[31:0]};
            b2 = sgn ? {{32{b[31]}}, b[31:0]} : {32'd0, b[31:0]};
        end
        if (sgn) p = $signed({{64{a2[63]}}, a2}) * $signed({{64{b2[63]}}, b2});
        else     p = {64'd0, a2} * {64'd0, b2};
        if (w64) return hi ? p[127:64] : p[63:0];
        return hi ? {{32{p[63]}}, p[63:32]} : {{32{p[31]}}, p[31:0]};
    endfunction

    // Multiplier stub: fixed LAT-cycle pipeline, no kill; kill_next drops one op's completion.
    logic kill_next;
    logic pv [LAT] = '{default: 1'b0};
    logic [63:0] py [LAT];
    logic [LG_ROB_ENTRIES-1:0] pr [LAT];
    logic [LG_PRF_ENTRIES-1:0] pp [LAT];

    always @(posedge clk) begin
        pv[0] <= mul_go && !kill_next;
        py[0] <= mref(mul_src_A, mul_src_B, mul_is_signed, mul_is_high, mul_is_64b);
        pr[0] <= mul_rob_ptr;
        pp[0] <= mul_prf_ptr;
        for (int i = 1; i < LAT; i++) begin
            pv[i] <= pv[i-1];
            py[i] <= py[i-1];
            pr[i] <= pr[i-1];
            pp[i] <= pp[i-1];
        end
    end
    assign mul_complete    = pv[LAT-1];
    assign mul_y           = py[LAT-1];
    assign mul_rob_ptr_out = pr[LAT-1];
    assign mul_prf_ptr_out = pp[LAT-1];

    // Scoreboard: expectations from requester payloads at handshake, checked in order at pop.
    mul_res_t exp_q [$];
    always @(negedge clk) begin
        mul_res_t e;
        if (!reset && !flush) begin
            if (wb_valid && wb_ready) begin
                check("wb_expected", 64'(exp_q.size() != 0), 64'd1);
                if (exp_q.size() != 0) begin
                    e = exp_q.pop_front();
                    check("wb_y", wb_y, e.y);
                    check("wb_rob", 64'(wb_rob_ptr), 64'(e.rob_ptr));
                    check("wb_prf", 64'(wb_prf_ptr), 64'(e.prf_ptr));
                end
            end
            if (req0_valid && req0_ready)
                exp_q.push_back('{mref(req0_src_A, req0_src_B, req0_is_signed, req0_is_high,
                                       req0_is_64b), req0_rob_ptr, req0_prf_ptr});
            if (req1_valid && req1_ready)
                exp_q.push_back('{mref(req1_src_A, req1_src_B, req1_is_signed, req1_is_high,
                                       req1_is_64b), req1_rob_ptr, req1_prf_ptr});
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic put0(input logic [63:0] a, input logic [63:0] b, input logic s,
                        input logic h, input logic w, input int rob, input int prf);
        req0_valid = 1'b1; req0_src_A = a; req0_src_B = b;
        req0_is_signed = s; req0_is_high = h; req0_is_64b = w;
        req0_rob_ptr = rob[LG_ROB_ENTRIES-1:0]; req0_prf_ptr = prf[LG_PRF_ENTRIES-1:0];
    endtask

    task automatic put1(input logic [63:0] a, input logic [63:0] b, input logic s,
                        input logic h, input logic w, input int rob, input int prf);
        req1_valid = 1'b1; req1_src_A = a; req1_src_B = b;
        req1_is_signed = s; req1_is_high = h; req1_is_64b = w;
        req1_rob_ptr = rob[LG_ROB_ENTRIES-1:0]; req1_prf_ptr = prf[LG_PRF_ENTRIES-1:0];
    endtask

    task automatic do_reset();
        reset = 1'b1; flush = 1'b0; kill_next = 1'b0;
        req0_valid = 1'b0; req1_valid = 1'b0;
        exp_q.delete();
        step();
        reset = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int acc, c0, c1, ng, exp_acc [5];
        logic t0, t1;
        logic exp_wbv [7];
        exp_acc = '{0, 1, 2, 3, 8};
        exp_wbv = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1};

        // reset state, with a requester pushing during reset
        reset = 1'b1; flush = 1'b0; kill_next = 1'b0; wb_ready = 1'b0;
        put0(64'd1, 64'd2, 1'b0, 1'b0, 1'b1, 1, 1);
        put1(64'd3, 64'd4, 1'b0, 1'b0, 1'b1, 2, 2);
        step(); #1;
        check("rst_ready0", 64'(req0_ready), 64'd0);
        check("rst_ready1", 64'(req1_ready), 64'd0);
        check("rst_go", 64'(mul_go), 64'd0);
        check("rst_wb_valid", 64'(wb_valid), 64'd0);
        check("rst_err", 64'(err), 64'd0);
        step();
        reset = 1'b0; req0_valid = 1'b0; req1_valid = 1'b0;
        #1;
        check("post_rst_wb_valid", 64'(wb_valid), 64'd0);
        check("post_rst_err", 64'(err), 64'd0);

        // single op: accept at cycle 0, writeback at cycle LAT+1
        do_reset(); wb_ready = 1'b1;
        put0(64'd7, 64'd6, 1'b0, 1'b0, 1'b1, 5, 9);
        #1;
        check("t1_ready0", 64'(req0_ready), 64'd1);
        check("t1_go", 64'(mul_go), 64'd1);
        check("t1_src_A", mul_src_A, 64'd7);
        step(); req0_valid = 1'b0;
        for (int k = 1; k < 5; k++) begin
            check("t1_wb_early", 64'(wb_valid), 64'd0);
            step();
        end
        check("t1_wb_valid", 64'(wb_valid), 64'd1);
        check("t1_wb_y", wb_y, 64'd42);
        check("t1_wb_rob", 64'(wb_rob_ptr), 64'd5);
        check("t1_wb_prf", 64'(wb_prf_ptr), 64'd9);
        check("t1_err", 64'(err), 64'd0);
        step();
        check("t1_wb_popped", 64'(wb_valid), 64'd0);
        check("t1_drain", 64'(exp_q.size()), 64'd0);

        // contention: grants alternate starting with req0, first 4 cycles back to back
        do_reset(); wb_ready = 1'b1; c0 = 0; c1 = 0; ng = 0;
        put0(64'(c0 + 2), 64'd1000, 1'b0, 1'b0, 1'b1, c0, c0 + 64);
        put1(-64'(c1 + 1), 64'd3, 1'b1, 1'b1, 1'b1, c1 + 32, c1 + 96);
        for (int cyc = 0; cyc < 30 && ng < 6; cyc++) begin
            #1;
            check("t2_onehot", 64'(req0_ready & req1_ready), 64'd0);
            if (cyc < 4) check("t2_burst", 64'(req0_ready | req1_ready), 64'd1);
            t0 = req0_ready; t1 = req1_ready;
            if (t0 | t1) begin
                check("t2_rr_order", 64'(t1), 64'(ng % 2));
                ng++;
            end
            step();
            if (t0) begin c0++; put0(64'(c0 + 2), 64'd1000, 1'b0, 1'b0, 1'b1, c0, c0 + 64); end
            if (t1) begin c1++; put1(-64'(c1 + 1), 64'd3, 1'b1, 1'b1, 1'b1, c1 + 32, c1 + 96); end
            if (ng >= 6) begin req0_valid = 1'b0; req1_valid = 1'b0; end
        end
        check("t2_grants", 64'(ng), 64'd6);
        repeat (12) step();
        check("t2_drain", 64'(exp_q.size()), 64'd0);

        // backpressure: exactly Q_DEPTH accepts, then resume in order once writeback drains
        do_reset(); wb_ready = 1'b0; c0 = 0; acc = 0;
        put0(64'(c0 * 7 + 3), 64'(c0 + 11), 1'b0, 1'b0, 1'b1, c0, c0 + 17);
        for (int cyc = 0; cyc < 12; cyc++) begin
            #1;
            t0 = req0_ready;
            if (t0) acc++;
            step();
            if (t0) begin c0++; put0(64'(c0 * 7 + 3), 64'(c0 + 11), 1'b0, 1'b0, 1'b1, c0, c0 + 17); end
        end
        #1;
        check("t3_accepts", 64'(acc), 64'(MUL_RESULT_Q_DEPTH));
        check("t3_wb_valid", 64'(wb_valid), 64'd1);
        wb_ready = 1'b1;
        #1;
        check("t3_pop_no_credit", 64'(req0_ready), 64'd0);
        step(); #1;
        check("t3_resume", 64'(req0_ready), 64'd1);
        for (int cyc = 0; cyc < 40 && acc < 8; cyc++) begin
            t0 = req0_ready;
            if (t0) acc++;
            step();
            if (t0) begin c0++; put0(64'(c0 * 7 + 3), 64'(c0 + 11), 1'b0, 1'b0, 1'b1, c0, c0 + 17); end
            if (acc >= 8) req0_valid = 1'b0;
            #1;
        end
        check("t3_total", 64'(acc), 64'd8);
        repeat (12) step();
        check("t3_drain", 64'(exp_q.size()), 64'd0);

        // flush with one queued and three in flight, then a fresh op
        do_reset(); wb_ready = 1'b0; c0 = 0;
        put0(64'(c0 + 5), 64'd9, 1'b0, 1'b0, 1'b1, c0, c0);
        for (int cyc = 0; cyc < 4; cyc++) begin
            #1;
            check("t4_accept", 64'(req0_ready), 64'd1);
            step();
            c0++; put0(64'(c0 + 5), 64'd9, 1'b0, 1'b0, 1'b1, c0, c0);
        end
        req0_valid = 1'b0;
        step();
        flush = 1'b1; wb_ready = 1'b1; req0_valid = 1'b1; exp_q.delete();
        #1;
        check("t4_pre_flush_wb", 64'(wb_valid), 64'd1);
        check("t4_flush_no_grant", 64'(req0_ready), 64'd0);
        step();
        flush = 1'b0; req0_valid = 1'b0;
        for (int k = 0; k < 5; k++) begin
            check("t4_wb_dropped", 64'(wb_valid), 64'd0);
            check("t4_err", 64'(err), 64'd0);
            step();
        end
        put0(64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 1'b1, 1'b1, 7, 3);
        #1;
        check("t4_new_accept", 64'(req0_ready), 64'd1);
        step(); req0_valid = 1'b0;
        for (int k = 1; k < 5; k++) step();
        check("t4_new_wb_valid", 64'(wb_valid), 64'd1);
        check("t4_new_wb_y", wb_y, 64'hFFFF_FFFF_FFFF_FFFE);
        step();
        check("t4_drain", 64'(exp_q.size()), 64'd0);

        // push and pop together at Q_DEPTH-1 with both pointers wrapping
        do_reset(); wb_ready = 1'b0; c0 = 0; acc = 0;
        put0(64'(c0 + 20), 64'(c0 + 30), 1'b0, 1'b0, 1'b1, c0 + 40, c0 + 50);
        for (int cyc = 0; cyc < 14; cyc++) begin
            if (cyc == 7) wb_ready = 1'b1;
            #1;
            if (cyc >= 7) check("t5_wb_valid", 64'(wb_valid), 64'(exp_wbv[cyc - 7]));
            t0 = req0_ready;
            if (t0) begin
                if (acc < 5) check("t5_accept_cycle", 64'(cyc), 64'(exp_acc[acc]));
                acc++;
            end
            step();
            if (t0) begin c0++; put0(64'(c0 + 20), 64'(c0 + 30), 1'b0, 1'b0, 1'b1, c0 + 40, c0 + 50); end
            if (acc >= 5) req0_valid = 1'b0;
        end
        check("t5_total", 64'(acc), 64'd5);
        repeat (4) step();
        check("t5_drain", 64'(exp_q.size()), 64'd0);

        // missing completion sets a sticky error LAT+1 cycles after issue
        do_reset(); wb_ready = 1'b1; kill_next = 1'b1;
        put0(64'd3, 64'd3, 1'b0, 1'b0, 1'b1, 1, 1);
        #1;
        check("t6_accept", 64'(req0_ready), 64'd1);
        step();
        kill_next = 1'b0; req0_valid = 1'b0; exp_q.delete();
        for (int k = 1; k < 5; k++) begin
            check("t6_err_early", 64'(err), 64'd0);
            step();
        end
        for (int k = 0; k < 4; k++) begin
            check("t6_err_sticky", 64'(err), 64'd1);
            check("t6_no_wb", 64'(wb_valid), 64'd0);
            step();
        end
        do_reset(); #1;
        check("t6_err_cleared", 64'(err), 64'd0);

        // reset in the middle of a burst with a queued result and ops in flight
        do_reset(); wb_ready = 1'b0; c0 = 0;
        put0(64'(c0 + 9), 64'd4, 1'b0, 1'b0, 1'b1, c0, c0);
        for (int cyc = 0; cyc < 5; cyc++) begin
            #1;
            t0 = req0_ready;
            step();
            if (t0) begin c0++; put0(64'(c0 + 9), 64'd4, 1'b0, 1'b0, 1'b1, c0, c0); end
        end
        reset = 1'b1; exp_q.delete();
        #1;
        check("t7_rst_ready0", 64'(req0_ready), 64'd0);
        check("t7_rst_go", 64'(mul_go), 64'd0);
        check("t7_rst_wb_valid", 64'(wb_valid), 64'd0);
        step();
        reset = 1'b0; req0_valid = 1'b0; wb_ready = 1'b1;
        for (int k = 0; k < 6; k++) begin
            #1;
            check("t7_no_stale_wb", 64'(wb_valid), 64'd0);
            check("t7_err", 64'(err), 64'd0);
            step();
        end
        check("t7_drain", 64'(exp_q.size()), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
